// File: rtl/tpum_pkg.sv
// rtl/tpum_pkg.sv - shared states, op codes and XBOX geometry for the TPUM sequencer
package tpum_pkg;

  localparam int XBOX_AW = 14;
  localparam int XBOX_DW = 1024;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b000_0001,
    S_LD_R1 = 7'b000_0010,
    S_LD_R2 = 7'b000_0100,
    S_EXEC  = 7'b000_1000,
    S_ST_RA = 7'b001_0000,
    S_NEXT  = 7'b010_0000,
    S_DONE  = 7'b100_0000
  } state_t;

  typedef enum logic [2:0] {
    OP_GEMN = 3'b001,
    OP_BNN  = 3'b010,
    OP_PUM  = 3'b100
  } op_t;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_GEMN) || (op == OP_BNN) || (op == OP_PUM);
  endfunction

endpackage

// File: rtl/tpum_xbox_sequencer_if.sv
// rtl/tpum_xbox_sequencer_if.sv - XBOX row request/ack port plus R1/R2 capture strobes
interface tpum_xbox_sequencer_if
  import tpum_pkg::*;
#(
  parameter int AW = XBOX_AW
);
  logic          pum_rd_from_xbox;
  logic          pum_wr_to_xbox;
  logic [AW-1:0] pum_xbox_addr;
  logic          xbox_ack;
  logic          r1_load;
  logic          r2_load;

  modport master (
    output pum_rd_from_xbox, pum_wr_to_xbox, pum_xbox_addr, r1_load, r2_load,
    input  xbox_ack
  );

  modport slave (
    input  pum_rd_from_xbox, pum_wr_to_xbox, pum_xbox_addr, r1_load, r2_load,
    output xbox_ack
  );
endinterface

// File: rtl/tpum_seq_addr_gen.sv
// rtl/tpum_seq_addr_gen.sv - latched base rows and row counter; row address for the current state
module tpum_seq_addr_gen
  import tpum_pkg::*;
#(
  parameter int AW    = XBOX_AW,
  parameter int ROW_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [AW-1:0]    base_a,
  input  logic [AW-1:0]    base_b,
  input  logic [AW-1:0]    base_c,
  input  logic             row_inc,
  input  state_t           state,
  output logic [ROW_W-1:0] row,
  output logic [AW-1:0]    addr
);
  logic [AW-1:0]    base_a_q, base_b_q, base_c_q;
  logic [ROW_W-1:0] row_q;
  logic [AW-1:0]    row_aw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      row_q    <= '0;
    end else if (load) begin
      base_a_q <= base_a;
      base_b_q <= base_b;
      base_c_q <= base_c;
      row_q    <= '0;
    end else if (row_inc) begin
      row_q <= row_q + 1'b1;
    end
  end

  // Row offset is truncated to AW so base+row wraps modulo the XBOX depth.
  assign row_aw = AW'(row_q);
  assign row    = row_q;

  always_comb begin
    addr = '0;
    unique case (state)
      S_LD_R1: addr = base_a_q + row_aw;
      S_LD_R2: addr = base_b_q + row_aw;
      S_ST_RA: addr = base_c_q + row_aw;
      default: addr = '0;
    endcase
  end
endmodule

// File: rtl/tpum_xbox_sequencer.sv
// rtl/tpum_xbox_sequencer.sv - per-row R1/R2 load, compute launch and RA store for one TPUM job
// Optional busy-cycle counter: TPUM_SEQ_PERF_CNT_EN
module tpum_xbox_sequencer
  import tpum_pkg::*;
#(
  parameter int AW    = XBOX_AW,
  parameter int ROW_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic [2:0]                    cfg_op,
  input  logic [ROW_W-1:0]              cfg_dim_a,
  input  logic [AW-1:0]                 cfg_base_a,
  input  logic [AW-1:0]                 cfg_base_b,
  input  logic [AW-1:0]                 cfg_base_c,
  tpum_xbox_sequencer_if.master         xbox,
  output logic                          exec_go,
  input  logic                          exec_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   perf_cycles
);
  state_t           state, next_state;
  logic             rd_q, wr_q, exec_go_q, done_q, err_q;
  logic             rd_d, wr_d, exec_go_d, done_d;
  logic [2:0]       op_q;
  logic [ROW_W-1:0] dim_q, row, row_next;
  logic             start_acc, rd_ack, wr_ack;

  assign start_acc = cfg_start && (state == S_IDLE);
  assign rd_ack    = rd_q && xbox.xbox_ack;
  assign wr_ack    = wr_q && xbox.xbox_ack;
  assign row_next  = row + 1'b1;

  tpum_seq_addr_gen #(.AW(AW), .ROW_W(ROW_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_acc),
    .base_a  (cfg_base_a),
    .base_b  (cfg_base_b),
    .base_c  (cfg_base_c),
    .row_inc (state == S_NEXT),
    .state   (state),
    .row     (row),
    .addr    (xbox.pum_xbox_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          if (!op_is_valid(cfg_op) || (cfg_dim_a == '0)) next_state = S_DONE;
          else                                            next_state = S_LD_R1;
        end
      end
      S_LD_R1: if (rd_ack) next_state = (op_q == OP_BNN) ? S_EXEC : S_LD_R2;
      S_LD_R2: if (rd_ack) next_state = S_EXEC;
      S_EXEC:  if (exec_done) next_state = S_ST_RA;
      S_ST_RA: if (wr_ack) next_state = S_NEXT;
      S_NEXT:  next_state = (row_next == dim_q) ? S_DONE : S_LD_R1;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Requests rise one cycle after state entry and drop on the edge that takes the ack.
  always_comb begin
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    exec_go_d = 1'b0;
    done_d    = 1'b0;
    rd_d      = ((state == S_LD_R1) || (state == S_LD_R2)) && (next_state == state);
    wr_d      = (state == S_ST_RA) && (next_state == state);
    exec_go_d = (next_state == S_EXEC) && (state != S_EXEC);
    done_d    = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      exec_go_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= '0;
      dim_q     <= '0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      exec_go_q <= exec_go_d;
      done_q    <= done_d;
      if (start_acc) begin
        op_q  <= cfg_op;
        dim_q <= cfg_dim_a;
        err_q <= !op_is_valid(cfg_op);
      end
    end
  end

  assign xbox.pum_rd_from_xbox = rd_q;
  assign xbox.pum_wr_to_xbox   = wr_q;
  assign xbox.r1_load          = (state == S_LD_R1) && rd_ack;
  assign xbox.r2_load          = (state == S_LD_R2) && rd_ack;
  assign exec_go               = exec_go_q;
  assign done                  = done_q;
  assign err                   = err_q;
  assign busy                  = (state != S_IDLE);

`ifdef TPUM_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                perf_q <= '0;
    else if (start_acc)                        perf_q <= '0;
    else if (busy && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_tpum_xbox_sequencer.sv
// tb/tb_tpum_xbox_sequencer.sv - table-driven jobs against an XBOX responder with an address scoreboard
module tb_tpum_xbox_sequencer;
  import tpum_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] dim;
    logic [13:0] a;
    logic [13:0] b;
    logic [13:0] c;
    int          ad;
    int          ed;
    logic        exp_err;
    int          exp_rows;
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic [13:0] addr;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [2:0]  cfg_op = '0;
  logic [15:0] cfg_dim_a = '0;
  logic [13:0] cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
  logic        exec_go, exec_done = 1'b0;
  logic        busy, done, err;
  logic [31:0] perf_cycles;

  tpum_xbox_sequencer_if #(.AW(14)) xbox_bus ();

  tpum_xbox_sequencer #(.AW(14), .ROW_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_op      (cfg_op),
    .cfg_dim_a   (cfg_dim_a),
    .cfg_base_a  (cfg_base_a),
    .cfg_base_b  (cfg_base_b),
    .cfg_base_c  (cfg_base_c),
    .xbox        (xbox_bus),
    .exec_go     (exec_go),
    .exec_done   (exec_done),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .perf_cycles (perf_cycles)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_miss = 0;
  int   ack_delay = 0, exec_delay = 0;
  int   ack_cnt = 0, exec_cnt_dly = 0;
  logic exec_pending = 1'b0;
  int   busy_cnt = 0, done_cnt = 0, go_cnt = 0, r1_cnt = 0, r2_cnt = 0;
  acc_t sb[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial xbox_bus.xbox_ack = 1'b0;

  // XBOX and compute-engine responder, driven shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    xbox_bus.xbox_ack = 1'b0;
    if (xbox_bus.pum_rd_from_xbox || xbox_bus.pum_wr_to_xbox) begin
      if (ack_cnt >= ack_delay) xbox_bus.xbox_ack = 1'b1;
      else ack_cnt++;
    end else begin
      ack_cnt = 0;
    end
    exec_done = 1'b0;
    if (exec_go) begin
      exec_pending = 1'b1;
      exec_cnt_dly = 0;
    end
    if (exec_pending) begin
      if (exec_cnt_dly >= exec_delay) begin
        exec_done    = 1'b1;
        exec_pending = 1'b0;
      end else exec_cnt_dly++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (exec_go) go_cnt++;
      if (xbox_bus.r1_load) r1_cnt++;
      if (xbox_bus.r2_load) r2_cnt++;
      if (xbox_bus.pum_rd_from_xbox && xbox_bus.pum_wr_to_xbox) check("rd_wr_exclusive", 1, 0);
      if ((xbox_bus.pum_rd_from_xbox || xbox_bus.pum_wr_to_xbox) && xbox_bus.xbox_ack) begin
        if (sb.size() == 0) check("unexpected_access", 1, 0);
        else begin
          acc_t e;
          e = sb.pop_front();
          check("access_kind", xbox_bus.pum_wr_to_xbox, e.is_wr);
          check("access_addr", xbox_bus.pum_xbox_addr, e.addr);
        end
      end
    end
  end

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; go_cnt = 0; r1_cnt = 0; r2_cnt = 0;
  endtask

  task automatic start_pulse(input logic [2:0] op, input logic [15:0] dim,
                             input logic [13:0] a, input logic [13:0] b, input logic [13:0] c);
    cfg_op = op; cfg_dim_a = dim; cfg_base_a = a; cfg_base_b = b; cfg_base_c = c;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic push_expected(input vec_t v);
    logic [13:0] r;
    for (int i = 0; i < v.exp_rows; i++) begin
      r = 14'(i);
      sb.push_back('{1'b0, 14'(v.a + r)});
      if (v.op != 3'b010) sb.push_back('{1'b0, 14'(v.b + r)});
      sb.push_back('{1'b1, 14'(v.c + r)});
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int expected_busy(input vec_t v);
    int nacc;
    nacc = (v.op == 3'b010) ? 2 : 3;
    return v.exp_rows * (nacc * (v.ad + 2) + (v.ed + 1) + 1) + 1;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int exp_busy;
    ack_delay = v.ad; exec_delay = v.ed;
    exp_busy = expected_busy(v);
    clear_counts();
    push_expected(v);
    start_pulse(v.op, v.dim, v.a, v.b, v.c);
    wait_done();
    check($sformatf("v%0d_done_count", idx), done_cnt, 1);
    check($sformatf("v%0d_err", idx), err, v.exp_err);
    check($sformatf("v%0d_exec_go_count", idx), go_cnt, v.exp_rows);
    check($sformatf("v%0d_r1_loads", idx), r1_cnt, v.exp_rows);
    check($sformatf("v%0d_r2_loads", idx), r2_cnt, (v.op == 3'b010) ? 0 : v.exp_rows);
    check($sformatf("v%0d_accesses_left", idx), sb.size(), 0);
    check($sformatf("v%0d_busy_cycles", idx), busy_cnt, exp_busy);
`ifdef TPUM_SEQ_PERF_CNT_EN
    check($sformatf("v%0d_perf_cycles", idx), perf_cycles, busy_cnt);
`else
    check($sformatf("v%0d_perf_cycles", idx), perf_cycles, 0);
`endif
    sb.delete();
  endtask

  initial begin
    //         op      dim  a        b        c        ad ed err rows
    vecs[0] = '{3'b001, 16'd2, 14'h010, 14'h020, 14'h030, 1, 0, 1'b0, 2};
    vecs[1] = '{3'b010, 16'd1, 14'h040, 14'h050, 14'h060, 0, 0, 1'b0, 1};
    vecs[2] = '{3'b100, 16'd3, 14'h100, 14'h200, 14'h300, 2, 3, 1'b0, 3};
    vecs[3] = '{3'b001, 16'd0, 14'h011, 14'h022, 14'h033, 0, 0, 1'b0, 0};
    vecs[4] = '{3'b011, 16'd2, 14'h011, 14'h022, 14'h033, 0, 0, 1'b1, 0};
    vecs[5] = '{3'b001, 16'd1, 14'h001, 14'h002, 14'h003, 3, 1, 1'b0, 1};
    vecs[6] = '{3'b100, 16'd2, 14'h3FFF, 14'h3FFE, 14'h3FFF, 0, 0, 1'b0, 2};
    vecs[7] = '{3'b000, 16'd1, 14'h005, 14'h006, 14'h007, 0, 0, 1'b1, 0};
    vecs[8] = '{3'b010, 16'd2, 14'h123, 14'h456, 14'h789, 1, 2, 1'b0, 2};

    repeat (2) @(negedge clk);
    check("reset_rd", xbox_bus.pum_rd_from_xbox, 0);
    check("reset_wr", xbox_bus.pum_wr_to_xbox, 0);
    check("reset_addr", xbox_bus.pum_xbox_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_done_err", {done, err, exec_go}, 0);
    check("reset_perf", perf_cycles, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Empty job: DONE is the only busy cycle, done lands two cycles after start.
    start_pulse(3'b001, 16'd0, 14'h0, 14'h0, 14'h0);
    check("dim0_busy_c1", busy, 1);
    check("dim0_done_c1", done, 0);
    @(negedge clk);
    check("dim0_done_c2", done, 1);
    check("dim0_busy_c2", busy, 0);
    repeat (2) @(negedge clk);

    // Start while busy must not disturb the running job.
    begin
      vec_t v;
      v = '{3'b001, 16'd2, 14'h0A0, 14'h0B0, 14'h0C0, 1, 0, 1'b0, 2};
      ack_delay = v.ad; exec_delay = v.ed;
      clear_counts();
      push_expected(v);
      start_pulse(v.op, v.dim, v.a, v.b, v.c);
      repeat (4) @(negedge clk);
      start_pulse(3'b010, 16'd5, 14'h555, 14'h666, 14'h777);
      wait_done();
      check("midstart_done_count", done_cnt, 1);
      check("midstart_accesses_left", sb.size(), 0);
      check("midstart_busy_cycles", busy_cnt, expected_busy(v));
      check("midstart_r2_loads", r2_cnt, 2);
      sb.delete();
    end

    // Reset while a store is outstanding.
    begin
      vec_t v;
      int   seen;
      v = '{3'b001, 16'd1, 14'h200, 14'h210, 14'h220, 6, 0, 1'b0, 1};
      ack_delay = v.ad; exec_delay = v.ed;
      clear_counts();
      push_expected(v);
      start_pulse(v.op, v.dim, v.a, v.b, v.c);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
        if (xbox_bus.pum_wr_to_xbox) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      check("rst_wr_reached", seen, 1);
      rst_n = 1'b0;
      #1;
      check("rst_wr_drop", xbox_bus.pum_wr_to_xbox, 0);
      check("rst_busy_drop", busy, 0);
      repeat (3) @(negedge clk);
      check("rst_no_done", {done, done_cnt[0]}, 0);
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      run_vec(vecs[1], 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
